// File: rtl/j1_pkg.sv
// Shared types and constants for the J1 RAM boot loader.
// Holds the loader state encoding, the default frame magic and the checksum helper.
package j1_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [3:0] {
    ST_SYNC    = 4'd0,
    ST_ADDR_HI = 4'd1,
    ST_ADDR_LO = 4'd2,
    ST_LEN_HI  = 4'd3,
    ST_LEN_LO  = 4'd4,
    ST_DATA_HI = 4'd5,
    ST_DATA_LO = 4'd6,
    ST_CSUM    = 4'd7,
    ST_DONE    = 4'd8,
    ST_ERROR   = 4'd9
  } loader_state_e;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

  // 8-bit modular checksum accumulation
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/j1_ram_loader.sv
// Framed byte-stream boot loader: writes big-endian words to J1 RAM port B and
// holds the core in reset until a frame with a good checksum has been loaded.
module j1_ram_loader
  import j1_pkg::*;
#(
  parameter logic [7:0] MAGIC      = LOADER_MAGIC,
  parameter int         ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  restart,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]           ram_data,
  output logic                  ram_write,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  loader_state_e         state;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [7:0]            addr_hi;
  logic [7:0]            len_hi;
  logic [7:0]            data_hi;
  word_t                 remaining;
  logic [7:0]            checksum;
  logic                  xfer;
  logic [7:0]            csum_next;
  word_t                 len_full;

  // Transfer qualifier and running checksum including the current byte
  always_comb begin
    xfer      = in_valid & in_ready;
    csum_next = csum_add(checksum, in_data);
    len_full  = {len_hi, in_data};
  end

  // Loader FSM, counters, checksum and all registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_SYNC;
      in_ready     <= 1'b1;
      ram_write    <= 1'b0;
      ram_addr     <= '0;
      ram_data     <= 16'h0000;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 16'h0000;
      checksum     <= 8'h00;
      addr_cnt     <= '0;
      addr_hi      <= 8'h00;
      len_hi       <= 8'h00;
      data_hi      <= 8'h00;
      remaining    <= 16'h0000;
    end else begin
      ram_write <= 1'b0;
      case (state)
        ST_SYNC: begin
          if (xfer && (in_data == MAGIC)) begin
            checksum     <= 8'h00;
            words_loaded <= 16'h0000;
            state        <= ST_ADDR_HI;
          end
        end
        ST_ADDR_HI: begin
          if (xfer) begin
            checksum <= csum_next;
            addr_hi  <= in_data;
            state    <= ST_ADDR_LO;
          end
        end
        ST_ADDR_LO: begin
          if (xfer) begin
            checksum <= csum_next;
            addr_cnt <= ADDR_WIDTH'({addr_hi, in_data});
            state    <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (xfer) begin
            checksum <= csum_next;
            len_hi   <= in_data;
            state    <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (xfer) begin
            checksum  <= csum_next;
            remaining <= len_full;
            state     <= (len_full == 16'h0000) ? ST_CSUM : ST_DATA_HI;
          end
        end
        ST_DATA_HI: begin
          if (xfer) begin
            checksum <= csum_next;
            data_hi  <= in_data;
            state    <= ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (xfer) begin
            checksum     <= csum_next;
            ram_write    <= 1'b1;
            ram_data     <= {data_hi, in_data};
            ram_addr     <= addr_cnt;
            addr_cnt     <= addr_cnt + 1'b1;
            words_loaded <= words_loaded + 16'd1;
            remaining    <= remaining - 16'd1;
            state        <= (remaining == 16'd1) ? ST_CSUM : ST_DATA_HI;
          end
        end
        ST_CSUM: begin
          if (xfer) begin
            checksum <= csum_next;
            in_ready <= 1'b0;
            if (csum_next == 8'h00) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= ST_ERROR;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end
        ST_DONE, ST_ERROR: begin
          if (restart) begin
            state    <= ST_SYNC;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        default: begin
          // Unreachable encodings recover to a safe, held state
          state    <= ST_SYNC;
          in_ready <= 1'b1;
          cpu_hold <= 1'b1;
          done     <= 1'b0;
          error    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_j1_ram_loader.sv
// Scoreboard bench for j1_ram_loader: stimulus pushes expected port-B writes,
// a negedge monitor pops and compares each ram_write pulse.
module tb_j1_ram_loader;

  logic        clock;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        restart;
  logic [15:0] ram_addr;
  logic [15:0] ram_data;
  logic        ram_write;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;
  int writes = 0;
  logic [31:0] exp_q[$];
  logic prev_write = 1'b0;

  j1_ram_loader dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .restart(restart), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_write(ram_write), .cpu_hold(cpu_hold), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the head of the expected queue
  always @(negedge clock) begin
    if (ram_write === 1'b1) begin
      writes++;
      checks++;
      if (prev_write) begin
        errors++;
        $display("FAIL write_pulse_width: ram_write high two cycles at addr %h", ram_addr);
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got %h<=%h expected none", ram_addr, ram_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({ram_addr, ram_data} !== e) begin
          errors++;
          $display("FAIL write: got %h<=%h expected %h<=%h", ram_addr, ram_data, e[31:16], e[15:0]);
        end
      end
    end
    prev_write = ram_write;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int n;
    if (gap_max > 0) tick($urandom_range(0, gap_max));
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick(1);
      n++;
    end
    if (n == 50) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: in_ready stuck low, got 0 expected 1");
    end
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input int gap_max);
    foreach (bytes[i]) send_byte(bytes[i], gap_max);
  endtask

  task automatic push_w(input logic [15:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic d, input logic e,
                            input logic h, input logic r, input logic [15:0] wl);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
    chk({tag, "_error"}, {31'd0, error}, {31'd0, e});
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, h});
    chk({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, r});
    chk({tag, "_words_loaded"}, {16'd0, words_loaded}, {16'd0, wl});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_status(tag, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
    chk({tag, "_ram_addr"}, {16'd0, ram_addr}, 32'd0);
    chk({tag, "_ram_data"}, {16'd0, ram_data}, 32'd0);
    chk({tag, "_ram_write"}, {31'd0, ram_write}, 32'd0);
  endtask

  initial begin
    logic [7:0] f1[$];
    logic [7:0] f1_bad[$];
    logic [7:0] f2[$];
    logic [7:0] f4[$];
    logic [7:0] f6[$];
    int w0;
    f1     = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h30};
    f1_bad = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h31};
    f2     = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'hFD};
    f4     = '{8'h00, 8'h7E, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF};
    f6     = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};

    reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; restart = 1'b0;
    tick(2);
    reset = 1'b0;
    chk_reset_vals("reset");

    // 1 basic frame
    push_w(16'h0010, 16'h1234); push_w(16'h0011, 16'hABCD);
    send_frame(f1, 0);
    chk_status("basic", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    // restart only in DONE: hold and ready come back next cycle
    do_restart();
    chk_status("restart", 1'b0, 1'b0, 1'b1, 1'b1, 16'd2);

    // 2 address wrap
    push_w(16'hFFFF, 16'h0001); push_w(16'h0000, 16'h0002);
    send_frame(f2, 0);
    chk_status("wrap", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    do_restart();

    // 3 bad checksum: writes still happen
    push_w(16'h0010, 16'h1234); push_w(16'h0011, 16'hABCD);
    send_frame(f1_bad, 0);
    chk_status("badcsum", 1'b0, 1'b1, 1'b1, 1'b0, 16'd2);
    tick(3);
    chk("badcsum_sticky", {31'd0, error}, 32'd1);
    do_restart();
    chk("badcsum_restart_err", {31'd0, error}, 32'd0);

    // 4 garbage before magic, zero length
    w0 = writes;
    send_frame(f4, 0);
    chk_status("zerolen", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    tick(2);
    chk("zerolen_writes", writes - w0, 32'd0);
    do_restart();

    // 5 stalls between bytes
    w0 = writes;
    push_w(16'h0010, 16'h1234); push_w(16'h0011, 16'hABCD);
    send_frame(f1, 3);
    chk_status("stall", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    tick(2);
    chk("stall_writes", writes - w0, 32'd2);
    do_restart();

    // 6 reset after DATA_HI of word 2, then wrap frame
    push_w(16'h0010, 16'h1234);
    send_frame(f6, 0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_reset_vals("midreset");
    push_w(16'hFFFF, 16'h0001); push_w(16'h0000, 16'h0002);
    send_frame(f2, 0);
    chk_status("after_reset", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);

    tick(3);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("total_writes", writes, 32'd11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
